// File: rtl/quad_decoder_4.sv
// Quadrature decoder: synchronizes and filters A/B, classifies accepted Gray-code
// transitions into up/down steps, tracks a modulo-16 position and flags illegal jumps.
module quad_decoder_4 #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       quad_a,
    input  logic       quad_b,
    input  logic       clr,
    input  logic       err_clr,
    output logic       step,
    output logic       up_down,
    output logic [3:0] bin_count,
    output logic       err
);
    // state | meaning
    // INIT  | waiting for the first accepted AB after reset; loads it silently
    // TRACK | every accepted AB is classified as up, down or diagonal (error)
    typedef enum logic {INIT = 1'b0, TRACK = 1'b1} state_t;

    localparam logic [3:0] FILT_MAX = 4'(FILTER_LEN);

    logic [SYNC_STAGES-1:0] sync_a_q, sync_b_q;
    logic [1:0] ab_sync, ab_prev_q, ab_acc_q, ab_acc_d;
    logic [3:0] filt_q, filt_d;
    logic       accept;
    logic       is_up, is_down, is_diag;
    state_t     state_q, state_d;
    logic       step_q, step_d;
    logic       up_q, up_d;
    logic       err_q, err_d;
    logic [3:0] cnt_q, cnt_d;

    assign ab_sync = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};

    // Counter restarts whenever the synchronized pair moves, so only a stable new value is accepted.
    always_comb begin
        filt_d = 4'd0;
        accept = 1'b0;
        if (ab_sync != ab_acc_q) begin
            if (ab_sync != ab_prev_q) begin
                filt_d = 4'd1;
            end else begin
                filt_d = filt_q + 4'd1;
            end
            if (filt_d == FILT_MAX) begin
                accept = 1'b1;
                filt_d = 4'd0;
            end
        end
    end

    assign ab_acc_d = accept ? ab_sync : ab_acc_q;

    // Gray order 00 -> 01 -> 11 -> 10 -> 00 counts up.
    assign is_up   = (ab_sync == {ab_acc_q[0], ~ab_acc_q[1]});
    assign is_down = (ab_sync == {~ab_acc_q[0], ab_acc_q[1]});
    assign is_diag = (ab_sync == ~ab_acc_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == INIT && accept) begin
            state_d = TRACK;
        end
    end

    always_comb begin
        step_d = 1'b0;
        up_d   = up_q;
        cnt_d  = cnt_q;
        err_d  = err_q & ~err_clr;
        if (accept && state_q == TRACK) begin
            if (is_up) begin
                step_d = 1'b1;
                up_d   = 1'b1;
                cnt_d  = cnt_q + 4'd1;
            end else if (is_down) begin
                step_d = 1'b1;
                up_d   = 1'b0;
                cnt_d  = cnt_q - 4'd1;
            end else if (is_diag) begin
                err_d  = 1'b1;
            end
        end
        if (clr) begin
            cnt_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_a_q  <= '0;
            sync_b_q  <= '0;
            ab_prev_q <= 2'b00;
            ab_acc_q  <= 2'b00;
            filt_q    <= 4'd0;
            step_q    <= 1'b0;
            up_q      <= 1'b1;
            cnt_q     <= 4'd0;
            err_q     <= 1'b0;
        end else begin
            sync_a_q  <= {sync_a_q[SYNC_STAGES-2:0], quad_a};
            sync_b_q  <= {sync_b_q[SYNC_STAGES-2:0], quad_b};
            ab_prev_q <= ab_sync;
            ab_acc_q  <= ab_acc_d;
            filt_q    <= filt_d;
            step_q    <= step_d;
            up_q      <= up_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign step      = step_q;
    assign up_down   = up_q;
    assign bin_count = cnt_q;
    assign err       = err_q;
endmodule

// File: tb/tb_quad_decoder_4.sv
// Scoreboard bench for quad_decoder_4: a delay-line/window reference model predicts
// every cycle's outputs; a negedge monitor pops and compares against the DUT.
module tb_quad_decoder_4;
    localparam int S = 2;
    localparam int F = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       quad_a = 1'b0;
    logic       quad_b = 1'b0;
    logic       clr = 1'b0;
    logic       err_clr = 1'b0;
    logic       step, up_down, err;
    logic [3:0] bin_count;

    int total = 0;
    int bad = 0;

    quad_decoder_4 #(.SYNC_STAGES(S), .FILTER_LEN(F)) dut (
        .clk(clk), .rst(rst), .quad_a(quad_a), .quad_b(quad_b),
        .clr(clr), .err_clr(err_clr),
        .step(step), .up_down(up_down), .bin_count(bin_count), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [1:0] hist[$];
    logic [1:0] m_acc;
    bit         m_init;
    bit         m_step, m_up, m_err;
    logic [3:0] m_cnt;
    logic [6:0] exp_q[$];

    function automatic int pos(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_edge();
        logic [1:0] v;
        bit stable, diag;
        int delta;
        if (!rst) begin
            hist.delete();
            for (int i = 0; i < S + F - 1; i++) hist.push_back(2'b00);
            m_acc = 2'b00; m_init = 1; m_step = 0; m_up = 1; m_cnt = 0; m_err = 0;
        end else begin
            m_step = 0;
            diag = 0;
            v = hist[S-1];
            stable = 1;
            for (int j = S - 1; j <= S + F - 2; j++) if (hist[j] != v) stable = 0;
            if (stable && v != m_acc) begin
                if (m_init) begin
                    m_init = 0;
                end else begin
                    delta = (pos(v) - pos(m_acc) + 4) % 4;
                    if (delta == 1) begin m_step = 1; m_up = 1; m_cnt = m_cnt + 4'd1; end
                    else if (delta == 3) begin m_step = 1; m_up = 0; m_cnt = m_cnt - 4'd1; end
                    else diag = 1;
                end
                m_acc = v;
            end
            if (clr) m_cnt = 0;
            m_err = diag || (m_err && !err_clr);
            hist.push_front({quad_a, quad_b});
            void'(hist.pop_back());
        end
    endtask

    task automatic cyc(input logic [1:0] ab, input logic c = 0, input logic e = 0,
                       input logic r = 1);
        @(negedge clk);
        quad_a = ab[1]; quad_b = ab[0]; clr = c; err_clr = e; rst = r;
        @(posedge clk);
        model_edge();
        exp_q.push_back({m_step, m_up, m_cnt, m_err});
    endtask

    task automatic hold(input logic [1:0] ab, input int n);
        for (int i = 0; i < n; i++) cyc(ab);
    endtask

    task automatic check(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    always @(negedge clk) begin
        logic [6:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if ({step, up_down, bin_count, err} !== e) begin
                bad++;
                if (bad <= 20)
                    $display("FAIL outputs t=%0t got step=%b up=%b cnt=%0d err=%b want step=%b up=%b cnt=%0d err=%b",
                             $time, step, up_down, bin_count, err, e[6], e[5], e[4:1], e[0]);
            end
        end
    end

    initial begin
        logic [1:0] ab;
        int len;
        for (int i = 0; i < 3; i++) cyc(2'b11, 0, 0, 0);
        hold(2'b11, 10);
        #1 check("init_cnt", bin_count, 0); check("init_err", err, 0);
        hold(2'b10, 10); hold(2'b00, 10);
        cyc(2'b00, 1);
        hold(2'b01, 10); hold(2'b11, 10); hold(2'b10, 10); hold(2'b00, 10); hold(2'b01, 10);
        #1 check("five_cnt", bin_count, 5); check("five_up", up_down, 1);
        for (int k = 0; k < 11; k++) begin
            ab = (k % 4 == 0) ? 2'b11 : (k % 4 == 1) ? 2'b10 : (k % 4 == 2) ? 2'b00 : 2'b01;
            hold(ab, 10);
        end
        #1 check("wrap_cnt", bin_count, 0);
        hold(2'b10, 10);
        #1 check("down_cnt", bin_count, 15); check("down_dir", up_down, 0);
        hold(2'b11, 10); hold(2'b01, 10);
        hold(2'b11, 3); hold(2'b01, 10);
        #1 check("glitch_cnt", bin_count, 13); check("glitch_err", err, 0);
        hold(2'b11, 10);
        #1 check("long_cnt", bin_count, 14);
        hold(2'b00, 10);
        #1 check("diag_err", err, 1); check("diag_cnt", bin_count, 14);
        hold(2'b11, 5); cyc(2'b11, 0, 1);
        #1 check("errclr_race", err, 1);
        hold(2'b11, 4); cyc(2'b11, 0, 1);
        #1 check("errclr", err, 0);
        hold(2'b10, 5); cyc(2'b10, 1, 0);
        #1 check("clr_step", step, 1); check("clr_cnt", bin_count, 0);
        hold(2'b00, 3); cyc(2'b00, 0, 0, 0);
        #1 check("rst_step", step, 0); check("rst_up", up_down, 1);
        check("rst_cnt", bin_count, 0); check("rst_err", err, 0);
        for (int s = 0; s < 300; s++) begin
            ab = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++)
                cyc(ab, ($urandom_range(0, 29) == 0), ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 199) != 0));
        end
        hold(2'b00, 2);
        @(negedge clk); #1;
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/quad_decoder_4.md
QUAD_DECODER_4 -- requirements
Module: quad_decoder_4

Interface
REQ-001 Parameter SYNC_STAGES, default 2: input synchronizer depth, legal range 2..4.
REQ-002 Parameter FILTER_LEN, default 4: consecutive stable synchronized samples required to accept a new A/B value, legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low (0 = reset, sampled on rising clk).
REQ-005 quad_a  input  1  asynchronous quadrature channel A.
REQ-006 quad_b  input  1  asynchronous quadrature channel B.
REQ-007 clr  input  1  synchronous count clear, active-high.
REQ-008 err_clr  input  1  clears sticky err, active-high.
REQ-009 step  output  1  one-cycle pulse per accepted legal transition.
REQ-010 up_down  output  1  direction of the last accepted step: 1 = up, 0 = down; drives an up/down counter's count control.
REQ-011 bin_count  output  4  position count, modulo 16.
REQ-012 err  output  1  sticky illegal-transition flag.

Function
REQ-013 quad_a and quad_b each pass through a SYNC_STAGES flop chain before any other use.
REQ-014 Filter: one shared counter runs while the synchronized AB pair differs from the accepted AB and is unchanged from the previous cycle; it restarts at 1 on any change and holds 0 while synchronized equals accepted.
REQ-015 Accepted AB updates on the edge at which the filter counter reaches FILTER_LEN.
REQ-016 Latency: with inputs stable from sampling edge 1, accepted AB updates on edge SYNC_STAGES+FILTER_LEN (6 with defaults).
REQ-017 step, up_down, bin_count and err update on the same edge as accepted AB; all outputs are registered.
REQ-018 Two-state FSM: INIT and TRACK.
REQ-019 INIT: the first accepted AB after reset loads without step, count change or err; FSM then moves to TRACK.
REQ-020 TRACK up sequence (old AB -> new AB): 00->01, 01->11, 11->10, 10->00; the result is step=1, up_down=1, bin_count+1.
REQ-021 TRACK down sequence: the reverse of REQ-020; the result is step=1, up_down=0, bin_count-1.
REQ-022 TRACK diagonal change (00<->11, 01<->10): err set, no step, bin_count and up_down unchanged, accepted AB takes the new value.
REQ-023 Wrap: up from 15 gives 0; down from 0 gives 15; no saturation, no overflow flag.
REQ-024 step is high for exactly one cycle per accepted legal transition; it is never high on consecutive cycles when FILTER_LEN > 1.
REQ-025 clr=1: bin_count <= 0 on that edge, overriding any simultaneous count update; step and up_down still reflect the transition.
REQ-026 err_clr=1 clears err unless a diagonal is accepted on the same edge; set wins.
REQ-027 A synchronized glitch shorter than FILTER_LEN cycles produces no output change.

Reset
REQ-028 While rst=0 at an edge, all of the following hold:
- sync chains <= 0
- filter counter <= 0
- accepted AB <= 00
- FSM <= INIT
- step <= 0
- up_down <= 1
- bin_count <= 0
- err <= 0
REQ-029 Reset asserted mid-filter or mid-sequence discards all progress; after release, behaviour is identical to power-up (INIT reload per REQ-019).
REQ-030 Reset has priority over clr, err_clr and all transitions.

Verification
REQ-031 Reset, inputs AB=11 held -> edge 6 after release: no step, no err, bin_count=0, FSM in TRACK.
REQ-032 From accepted 00, drive 01,11,10,00,01 each held 10 cycles -> 5 steps, up_down=1, bin_count=5; repeat to 16 steps -> bin_count wraps to 0.
REQ-033 From count 0, accepted 00, drive 10 -> step, up_down=0, bin_count=15.
REQ-034 Accepted 01, apply 3-cycle pulse on A -> no step, count and err unchanged; same pulse held 4+ cycles after sync -> accepted.
REQ-035 Accepted 00, drive 11 -> err=1, count unchanged; err_clr with simultaneous new diagonal -> err stays 1; err_clr alone -> err=0.
REQ-036 clr asserted on the edge of an up step from count 7 -> step=1, up_down=1, bin_count=0; rst=0 mid-filter -> all outputs at reset values on the next edge.
